// File: rtl/conv_pkg.sv
// Shared types and helpers for the parametrised sliding-window convolver.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic signed [DEFAULT_DATA_W-1:0] pix_t;
    typedef logic signed [DEFAULT_DATA_W-1:0] weight_t;

    // A K*K sum of full-precision DATA_W x DATA_W products never overflows this width.
    function automatic int acc_width(input int k, input int data_w);
        return 2 * data_w + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_ctrl.sv
// Control FSM for the convolver: weight indexing, raster col/row tracking and datapath strobes.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int IDX_W = $clog2(K * K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             reload,
    input  logic             w_valid,
    input  logic             pix_valid,
    input  logic             out_valid,
    input  logic             out_ready,
    output logic             w_ready,
    output logic             pix_ready,
    output logic             busy,
    output logic             done,
    output logic             weight_we,
    output logic [IDX_W-1:0] weight_idx,
    output logic             shift_en,
    output logic             win_complete
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(K * K - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

    state_t           state;
    state_t           state_next;
    logic             loaded;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             w_fire;
    logic             pix_fire;
    logic             last_pix;
    logic             out_free;

    assign w_fire   = w_valid && w_ready;
    assign pix_fire = pix_valid && pix_ready;
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
    // The output register can take a new value if empty or retiring this cycle.
    assign out_free = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DONE) && out_free;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (reload || !loaded) ? LOAD_W : RUN;
            LOAD_W:  if (w_fire && (weight_idx == IDX_LAST)) state_next = RUN;
            RUN:     if (pix_fire && last_pix) state_next = DONE;
            DONE:    if (out_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        w_ready   = (state == LOAD_W);
        pix_ready = (state == RUN) && out_free;
    end

    assign weight_we    = w_fire;
    assign shift_en     = pix_fire;
    assign win_complete = pix_fire && (col >= COL_FIRST) && (row >= ROW_FIRST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            weight_idx <= '0;
            loaded     <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            if (state != LOAD_W) begin
                weight_idx <= '0;
            end else if (w_fire) begin
                weight_idx <= (weight_idx == IDX_LAST) ? '0 : weight_idx + 1'b1;
                if (weight_idx == IDX_LAST) loaded <= 1'b1;
            end

            if (state != RUN) begin
                col <= '0;
                row <= '0;
            end else if (pix_fire) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/convolver_param.sv
// Parametrised K x K sliding-window convolver: weight store, line buffers, window, adder tree
// and a single held output register behind a valid/ready handshake.
module convolver_param
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ACC_W  = acc_width(K, DATA_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     reload,
    input  logic                     w_valid,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     w_ready,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W  = $clog2(K * K);
    localparam int PROD_W = 2 * DATA_W;

    logic             weight_we;
    logic [IDX_W-1:0] weight_idx;
    logic             shift_en;
    logic             win_complete;

    logic signed [DATA_W-1:0] weight   [K*K];
    logic signed [DATA_W-1:0] win      [K][K];
    logic signed [DATA_W-1:0] win_next [K][K];
    logic signed [DATA_W-1:0] line_buf [K-1][IMG_W];
    logic signed [DATA_W-1:0] row_in   [K];
    logic signed [ACC_W-1:0]  win_sum;

    conv_ctrl #(
        .K     (K),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .IDX_W (IDX_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .reload       (reload),
        .w_valid      (w_valid),
        .pix_valid    (pix_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .w_ready      (w_ready),
        .pix_ready    (pix_ready),
        .busy         (busy),
        .done         (done),
        .weight_we    (weight_we),
        .weight_idx   (weight_idx),
        .shift_en     (shift_en),
        .win_complete (win_complete)
    );

    // Row K-1 is the live pixel; each line buffer tail delivers the same column one row higher.
    always_comb begin
        row_in[K-1] = pix_data;
        for (int i = 0; i < K - 1; i++) begin
            row_in[i] = line_buf[i][IMG_W-1];
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_next[i][j] = win[i][j+1];
            end
            win_next[i][K-1] = row_in[i];
        end
    end

    // NOTE: storage arrays carry no reset; their contents are always written before being used.
    always_ff @(posedge clk) begin
        if (weight_we) weight[weight_idx] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            win <= win_next;
            for (int i = 0; i < K - 1; i++) begin
                line_buf[i][0] <= row_in[i+1];
                for (int n = 1; n < IMG_W; n++) begin
                    line_buf[i][n] <= line_buf[i][n-1];
                end
            end
        end
    end

    // The sum is taken over the window as it will look after this pixel shifts in.
    always_comb begin
        logic signed [PROD_W-1:0] prod;
        prod    = '0;
        win_sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod    = PROD_W'(weight[i*K+j]) * PROD_W'(win_next[i][j]);
                win_sum = win_sum + ACC_W'(prod);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (win_complete) begin
            out_valid <= 1'b1;
            out_data  <= win_sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_convolver_param.sv
// Randomised scoreboard bench for convolver_param against a direct 2-D convolution model.
module tb_convolver_param;
    import conv_pkg::*;

    localparam int K      = 3;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ACC_W  = acc_width(K, DATA_W);
    localparam int NPIX   = IMG_W * IMG_H;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic                     reload;
    logic                     w_valid;
    logic signed [DATA_W-1:0] w_data;
    logic                     w_ready;
    logic                     pix_valid;
    logic signed [DATA_W-1:0] pix_data;
    logic                     pix_ready;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    int tests    = 0;
    int failed   = 0;
    int exp_q[$];
    int kern[K*K];
    int img[NPIX];
    int rdy_mode = 0;
    int done_cnt = 0;

    convolver_param #(
        .K      (K),
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .reload    (reload),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every handshake retires the oldest expected result.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL spurious_out: got %0d, expected no result", out_data);
            end else begin
                check("out_data", $signed(out_data), exp_q.pop_front());
            end
        end
    end

    // Reference: plain 2-D correlation over every fully interior window, raster order.
    task automatic issue_frame();
        for (int r = 0; r <= IMG_H - K; r++) begin
            for (int c = 0; c <= IMG_W - K; c++) begin
                int sum;
                sum = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        sum += kern[i*K+j] * img[(r+i)*IMG_W + c + j];
                exp_q.push_back(sum);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_pix_ready", pix_ready, 0);
    endtask

    task automatic pulse_start(input bit rl);
        @(posedge clk);
        #1;
        start  = 1'b1;
        reload = rl;
        @(posedge clk);
        #1;
        start  = 1'b0;
        reload = 1'b0;
    endtask

    task automatic load_weights(input int gap_pct);
        for (int n = 0; n < K * K; n++) begin
            bit ok;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                w_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            w_valid = 1'b1;
            w_data  = DATA_W'(kern[n]);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (w_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("w_ready_wait", ok, 1);
            @(posedge clk);
            #1;
            w_valid = 1'b0;
        end
    endtask

    task automatic feed_pixels(input int n, input int gap_pct);
        for (int p = 0; p < n; p++) begin
            bit ok;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            pix_valid = 1'b1;
            pix_data  = DATA_W'(img[p]);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (pix_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("pix_ready_wait", ok, 1);
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
        end
    endtask

    task automatic wait_frame_done(input int d0);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, d0 + 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic do_frame(input bit rl, input bit need_load, input int gap_pct);
        int d0;
        d0 = done_cnt;
        pulse_start(rl);
        check("w_ready_after_start", w_ready, need_load);
        check("pix_ready_after_start", pix_ready, !need_load);
        check("busy_after_start", busy, 1);
        if (need_load) load_weights(gap_pct);
        issue_frame();
        feed_pixels(NPIX, gap_pct);
        wait_frame_done(d0);
    endtask

    task automatic stall_check();
        bit                      seen;
        logic signed [ACC_W-1:0] cap;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_out_valid_seen", seen, 1);
        cap = out_data;
        repeat (5) begin
            @(negedge clk);
            check("stall_pix_ready", pix_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, cap);
        end
        rdy_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        reload    = 1'b0;
        w_valid   = 1'b0;
        w_data    = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Ones kernel over a 0..15 ramp; reload=0 after reset must still load.
        foreach (kern[n]) kern[n] = 1;
        foreach (img[p]) img[p] = p;
        do_frame(1'b0, 1'b1, 0);

        // Kernel reuse: straight to RUN.
        foreach (img[p]) img[p] = int'($urandom_range(0, 255)) - 128;
        do_frame(1'b0, 1'b0, 0);

        // Extreme negative operands.
        foreach (kern[n]) kern[n] = -128;
        foreach (img[p]) img[p] = -128;
        do_frame(1'b1, 1'b1, 0);

        // Back-pressure while a result is held.
        begin
            int d0;
            foreach (img[p]) img[p] = int'($urandom_range(0, 255)) - 128;
            rdy_mode = 2;
            d0 = done_cnt;
            pulse_start(1'b0);
            issue_frame();
            fork
                feed_pixels(NPIX, 0);
                stall_check();
            join
            wait_frame_done(d0);
        end

        // Asynchronous reset in the middle of a frame, with a result pending.
        begin
            int d0;
            d0 = done_cnt;
            pulse_start(1'b0);
            issue_frame();
            feed_pixels(11, 0);
            #2;
            reset = 1'b0;
            #1;
            check_reset_outputs();
            exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b1;
            check("no_done_after_reset", done_cnt, d0);
        end

        foreach (kern[n]) kern[n] = int'($urandom_range(0, 255)) - 128;
        foreach (img[p]) img[p] = int'($urandom_range(0, 255)) - 128;
        do_frame(1'b0, 1'b1, 0);

        // Random gaps, random back-pressure, random kernel reloads.
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            bit rl;
            rl = 1'($urandom_range(0, 1));
            if (rl) foreach (kern[n]) kern[n] = int'($urandom_range(0, 255)) - 128;
            foreach (img[p]) img[p] = int'($urandom_range(0, 255)) - 128;
            do_frame(rl, rl, 50);
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
